// File: rtl/uart_rx_depacketizer.sv
// rtl/uart_rx_depacketizer.sv - UART receiver: 2-flop sync, start/data/stop FSM, valid/ready byte output
// Reports framing errors and overruns as single-cycle pulses.
module uart_rx_depacketizer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic            sync1_q;
    logic            rx_s_q;
    logic            armed_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            frame_err_q;
    logic            overrun_err_q;
    logic            xfer;

    assign xfer = rx_valid_q & rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            sync1_q       <= rx_in;
            rx_s_q        <= sync1_q;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            if (xfer) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    // armed_q blocks retriggering on a line that stayed low after a framing error
                    if (rx_s_q) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q     <= '0;
                        bit_idx_q <= 3'd0;
                        state_q   <= rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rx_s_q) begin
                            armed_q <= 1'b1;
                            // A same-cycle transfer frees the output register for the new byte
                            if (!rx_valid_q || xfer) begin
                                rx_valid_q <= 1'b1;
                                rx_data_q  <= shift_q;
                            end else begin
                                overrun_err_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            armed_q     <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_busy     = (state_q != IDLE);
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
endmodule

// File: tb/tb_uart_rx_depacketizer.sv
// tb/tb_uart_rx_depacketizer.sv - directed bench for uart_rx_depacketizer at C=16, 4 and 868
module tb_uart_rx_depacketizer;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ready = 1'b1;
    logic [2:0]      rx_line = 3'b111;
    logic [2:0][7:0] d_w;
    logic [2:0]      v_w;
    logic [2:0]      busy_w;
    logic [2:0]      fe_w;
    logic [2:0]      ov_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CP = (g == 0) ? 16 : ((g == 1) ? 4 : 868);
        uart_rx_depacketizer #(.CLKS_PER_BIT(CP)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .rx_in      (rx_line[g]),
            .rx_data    (d_w[g]),
            .rx_valid   (v_w[g]),
            .rx_ready   (ready),
            .rx_busy    (busy_w[g]),
            .frame_err  (fe_w[g]),
            .overrun_err(ov_w[g])
        );
    end

    logic [7:0] got [3][64];
    int         got_n [3] = '{0, 0, 0};
    int         vcyc [3] = '{0, 0, 0};
    int         rise_cyc [3] = '{0, 0, 0};
    int         ferr_n [3] = '{0, 0, 0};
    int         ovr_n [3] = '{0, 0, 0};
    logic [2:0] prev_v = 3'b000;

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (v_w[g]) vcyc[g]++;
            if (v_w[g] && !prev_v[g]) rise_cyc[g] = cyc;
            if (v_w[g] && ready && got_n[g] < 64) begin
                got[g][got_n[g]] = d_w[g];
                got_n[g]++;
            end
            if (fe_w[g]) ferr_n[g]++;
            if (ov_w[g]) ovr_n[g]++;
            prev_v[g] = v_w[g];
        end
    end

    task automatic drive_bit(input int g, input logic v, input int n);
        rx_line[g] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int g, input logic [7:0] b, input logic stop, input int c);
        drive_bit(g, 1'b0, c);
        for (int i = 0; i < 8; i++) drive_bit(g, b[i], c);
        drive_bit(g, stop, c);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({d_w[g], v_w[g], busy_w[g], fe_w[g], ov_w[g]} !== 12'h000) begin
                errors++;
                $display("FAIL %s dut%0d outputs got data=%h v=%b busy=%b fe=%b ov=%b want all 0",
                         tag, g, d_w[g], v_w[g], busy_w[g], fe_w[g], ov_w[g]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_single(input int g, input int c, input logic [7:0] b, input int lat);
        int base, vb, fb, ob, t0;
        ready = 1'b1;
        base = got_n[g]; vb = vcyc[g]; fb = ferr_n[g]; ob = ovr_n[g];
        @(posedge clk); #1;
        t0 = cyc;
        send_frame(g, b, 1'b1, c);
        drive_bit(g, 1'b1, 2 * c);
        checks++;
        if (got_n[g] - base !== 1) begin
            errors++; $display("FAIL single dut%0d count got %0d want 1", g, got_n[g] - base);
        end
        checks++;
        if (got[g][base] !== b) begin
            errors++; $display("FAIL single dut%0d data got %h want %h", g, got[g][base], b);
        end
        checks++;
        if (rise_cyc[g] - t0 !== lat) begin
            errors++; $display("FAIL single dut%0d latency got %0d want %0d", g, rise_cyc[g] - t0, lat);
        end
        checks++;
        if (vcyc[g] - vb !== 1) begin
            errors++; $display("FAIL single dut%0d valid_cycles got %0d want 1", g, vcyc[g] - vb);
        end
        checks++;
        if ((ferr_n[g] - fb) + (ovr_n[g] - ob) !== 0) begin
            errors++; $display("FAIL single dut%0d errors got fe=%0d ov=%0d want 0", g, ferr_n[g] - fb, ovr_n[g] - ob);
        end
    endtask

    task automatic test_back_to_back(input int g, input int c);
        logic [7:0] exp3 [3] = '{8'h00, 8'hFF, 8'h3C};
        int base, fb, ob;
        ready = 1'b1;
        base = got_n[g]; fb = ferr_n[g]; ob = ovr_n[g];
        for (int i = 0; i < 3; i++) send_frame(g, exp3[i], 1'b1, c);
        drive_bit(g, 1'b1, 2 * c);
        checks++;
        if (got_n[g] - base !== 3) begin
            errors++; $display("FAIL b2b dut%0d count got %0d want 3", g, got_n[g] - base);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[g][base + i] !== exp3[i]) begin
                errors++; $display("FAIL b2b dut%0d byte%0d got %h want %h", g, i, got[g][base + i], exp3[i]);
            end
        end
        checks++;
        if ((ferr_n[g] - fb) + (ovr_n[g] - ob) !== 0) begin
            errors++; $display("FAIL b2b dut%0d errors got fe=%0d ov=%0d want 0", g, ferr_n[g] - fb, ovr_n[g] - ob);
        end
    endtask

    task automatic test_framing();
        int base, fb, vb;
        ready = 1'b1;
        base = got_n[0]; fb = ferr_n[0]; vb = vcyc[0];
        send_frame(0, 8'h5A, 1'b0, 16);
        drive_bit(0, 1'b0, 640);
        checks++;
        if (ferr_n[0] - fb !== 1) begin
            errors++; $display("FAIL framing fe_cycles got %0d want 1", ferr_n[0] - fb);
        end
        checks++;
        if (vcyc[0] - vb !== 0) begin
            errors++; $display("FAIL framing valid_cycles got %0d want 0", vcyc[0] - vb);
        end
        checks++;
        if (busy_w[0] !== 1'b0) begin
            errors++; $display("FAIL framing busy_while_low got %b want 0", busy_w[0]);
        end
        drive_bit(0, 1'b1, 32);
        send_frame(0, 8'h11, 1'b1, 16);
        drive_bit(0, 1'b1, 32);
        checks++;
        if (got_n[0] - base !== 1 || got[0][base] !== 8'h11) begin
            errors++; $display("FAIL framing after_break got n=%0d data=%h want n=1 data=11", got_n[0] - base, got[0][base]);
        end
        checks++;
        if (ferr_n[0] - fb !== 1) begin
            errors++; $display("FAIL framing fe_total got %0d want 1", ferr_n[0] - fb);
        end
    endtask

    task automatic test_glitch();
        int vb, fb;
        vb = vcyc[0]; fb = ferr_n[0];
        drive_bit(0, 1'b0, 4);
        checks++;
        if (busy_w[0] !== 1'b1) begin
            errors++; $display("FAIL glitch busy_in_start got %b want 1", busy_w[0]);
        end
        drive_bit(0, 1'b1, 40);
        checks++;
        if (busy_w[0] !== 1'b0) begin
            errors++; $display("FAIL glitch busy_after got %b want 0", busy_w[0]);
        end
        checks++;
        if ((vcyc[0] - vb) + (ferr_n[0] - fb) !== 0) begin
            errors++; $display("FAIL glitch outputs got v=%0d fe=%0d want 0", vcyc[0] - vb, ferr_n[0] - fb);
        end
    endtask

    task automatic test_overrun();
        int base, ob, fb;
        base = got_n[0]; ob = ovr_n[0]; fb = ferr_n[0];
        ready = 1'b0;
        send_frame(0, 8'h12, 1'b1, 16);
        send_frame(0, 8'h34, 1'b1, 16);
        drive_bit(0, 1'b1, 32);
        checks++;
        if (v_w[0] !== 1'b1 || d_w[0] !== 8'h12) begin
            errors++; $display("FAIL overrun held got v=%b data=%h want v=1 data=12", v_w[0], d_w[0]);
        end
        checks++;
        if (ovr_n[0] - ob !== 1) begin
            errors++; $display("FAIL overrun pulse_cycles got %0d want 1", ovr_n[0] - ob);
        end
        checks++;
        if (ferr_n[0] - fb !== 0) begin
            errors++; $display("FAIL overrun fe got %0d want 0", ferr_n[0] - fb);
        end
        ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (got_n[0] - base !== 1 || got[0][base] !== 8'h12) begin
            errors++; $display("FAIL overrun drain got n=%0d data=%h want n=1 data=12", got_n[0] - base, got[0][base]);
        end
        checks++;
        if (v_w[0] !== 1'b0) begin
            errors++; $display("FAIL overrun valid_after got %b want 0", v_w[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'h77;
        ready = 1'b0;
        send_frame(0, 8'h5E, 1'b1, 16);
        drive_bit(0, 1'b1, 16);
        checks++;
        if (v_w[0] !== 1'b1 || d_w[0] !== 8'h5E) begin
            errors++; $display("FAIL rstmid pending got v=%b data=%h want v=1 data=5e", v_w[0], d_w[0]);
        end
        drive_bit(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(0, b[i], 16);
        drive_bit(0, b[4], 12);
        checks++;
        if (busy_w[0] !== 1'b1) begin
            errors++; $display("FAIL rstmid busy_in_data got %b want 1", busy_w[0]);
        end
        rst = 1'b1;
        rx_line[0] = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rstmid");
        rst = 1'b0;
        ready = 1'b1;
        drive_bit(0, 1'b1, 32);
        test_single(0, 16, 8'hC3, 155);
    endtask

    initial begin
        test_reset();
        test_single(0, 16, 8'hA5, 155);
        test_back_to_back(0, 16);
        test_framing();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_single(1, 4, 8'hA5, 41);
        test_back_to_back(1, 4);
        test_single(2, 868, 8'hA5, 8249);
        test_back_to_back(2, 868);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
